// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the register bus; one transaction in flight at a time.
// Define REG_ARB_TIMEOUT_EN to abort reads the slave never answers.
module reg_bus_arbiter #(
   parameter int                ADDR_W       = 16,
   parameter int                DATA_W       = 32,
   parameter int                TIMEOUT      = 255,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  m0_wr_en,
   input  logic                  m0_rd_en,
   input  logic [DATA_W/8-1:0]   m0_be,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W-1:0]     m0_wdata,
   output logic                  m0_ready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic                  m0_rd_rdy,
   output logic                  m0_drop,
   input  logic                  m1_wr_en,
   input  logic                  m1_rd_en,
   input  logic [DATA_W/8-1:0]   m1_be,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W-1:0]     m1_wdata,
   output logic                  m1_ready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  m1_rd_rdy,
   output logic                  m1_drop,
   output logic                  bus_wr_en,
   output logic                  bus_rd_en,
   output logic [DATA_W/8-1:0]   bus_be,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic [DATA_W-1:0]     bus_rdata,
   input  logic                  bus_rd_rdy,
   output logic                  rd_err
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR      = 2'd1,
      ST_RD_WAIT = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic                      owner_q, owner_d;
   logic                      last_grant_q, last_grant_d;
   logic                      grant_s;
   logic [1:0]                slot_valid_q, slot_valid_d;
   logic [1:0]                slot_wr_q, slot_wr_d;
   logic [1:0][BE_W-1:0]      slot_be_q, slot_be_d;
   logic [1:0][ADDR_W-1:0]    slot_addr_q, slot_addr_d;
   logic [1:0][DATA_W-1:0]    slot_wdata_q, slot_wdata_d;
   logic [1:0]                ready_q, ready_d;
   logic [1:0]                drop_q, drop_d;
   logic [1:0]                rd_rdy_q, rd_rdy_d;
   logic [1:0][DATA_W-1:0]    rdata_q, rdata_d;
   logic                      bus_wr_en_q, bus_wr_en_d;
   logic                      bus_rd_en_q, bus_rd_en_d;
   logic [BE_W-1:0]           bus_be_q, bus_be_d;
   logic [ADDR_W-1:0]         bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]         bus_wdata_q, bus_wdata_d;

   logic [1:0]                req_wr_s, req_rd_s;
   logic [1:0][BE_W-1:0]      req_be_s;
   logic [1:0][ADDR_W-1:0]    req_addr_s;
   logic [1:0][DATA_W-1:0]    req_wdata_s;

`ifdef REG_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      rd_err_q, rd_err_d;
   assign rd_err = rd_err_q;
`else
   logic                      unused_cfg_s;
   assign unused_cfg_s = ^{TIMEOUT_DATA, TIMEOUT};
   assign rd_err       = 1'b0;
`endif

   assign req_wr_s    = {m1_wr_en, m0_wr_en};
   assign req_rd_s    = {m1_rd_en, m0_rd_en};
   assign req_be_s    = {m1_be, m0_be};
   assign req_addr_s  = {m1_addr, m0_addr};
   assign req_wdata_s = {m1_wdata, m0_wdata};

   // Next-state logic: grant/issue, read completion, request capture and drop detection.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      grant_s      = 1'b0;
      slot_valid_d = slot_valid_q;
      slot_wr_d    = slot_wr_q;
      slot_be_d    = slot_be_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      drop_d       = 2'b00;
      rd_rdy_d     = 2'b00;
      rdata_d      = rdata_q;
      bus_wr_en_d  = 1'b0;
      bus_rd_en_d  = 1'b0;
      bus_be_d     = bus_be_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      rd_err_d     = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (slot_valid_q != 2'b00) begin
               // On a tie the master that did not win last time goes first.
               if (slot_valid_q == 2'b11) begin
                  grant_s = ~last_grant_q;
               end else begin
                  grant_s = slot_valid_q[1];
               end
               owner_d               = grant_s;
               last_grant_d          = grant_s;
               slot_valid_d[grant_s] = 1'b0;
               bus_be_d              = slot_be_q[grant_s];
               bus_addr_d            = slot_addr_q[grant_s];
               bus_wdata_d           = slot_wdata_q[grant_s];
               if (slot_wr_q[grant_s]) begin
                  bus_wr_en_d = 1'b1;
                  state_d     = ST_WR;
               end else begin
                  bus_rd_en_d = 1'b1;
                  state_d     = ST_RD_WAIT;
`ifdef REG_ARB_TIMEOUT_EN
                  cnt_d       = {CNT_W{1'b0}};
`endif
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (bus_rd_rdy) begin
               rdata_d[owner_q]  = bus_rdata;
               rd_rdy_d[owner_q] = 1'b1;
               state_d           = ST_IDLE;
            end
`ifdef REG_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdata_d[owner_q]  = TIMEOUT_DATA;
               rd_rdy_d[owner_q] = 1'b1;
               rd_err_d          = 1'b1;
               state_d           = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            else begin
               state_d = ST_RD_WAIT;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Ready is judged on the registered value, so a slot freed this edge still drops.
      for (int n = 0; n < 2; n++) begin
         if (req_wr_s[n] || req_rd_s[n]) begin
            if (ready_q[n]) begin
               slot_valid_d[n] = 1'b1;
               slot_wr_d[n]    = req_wr_s[n];
               slot_be_d[n]    = req_be_s[n];
               slot_addr_d[n]  = req_addr_s[n];
               slot_wdata_d[n] = req_wdata_s[n];
            end else begin
               drop_d[n] = 1'b1;
            end
         end else begin
            drop_d[n] = 1'b0;
         end
      end

      ready_d[0] = ~slot_valid_d[0] & ~((state_d != ST_IDLE) & ~owner_d);
      ready_d[1] = ~slot_valid_d[1] & ~((state_d != ST_IDLE) & owner_d);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         slot_valid_q <= 2'b00;
         slot_wr_q    <= 2'b00;
         slot_be_q    <= {(2*BE_W){1'b0}};
         slot_addr_q  <= {(2*ADDR_W){1'b0}};
         slot_wdata_q <= {(2*DATA_W){1'b0}};
         ready_q      <= 2'b11;
         drop_q       <= 2'b00;
         rd_rdy_q     <= 2'b00;
         rdata_q      <= {(2*DATA_W){1'b0}};
         bus_wr_en_q  <= 1'b0;
         bus_rd_en_q  <= 1'b0;
         bus_be_q     <= {BE_W{1'b0}};
         bus_addr_q   <= {ADDR_W{1'b0}};
         bus_wdata_q  <= {DATA_W{1'b0}};
`ifdef REG_ARB_TIMEOUT_EN
         cnt_q        <= {CNT_W{1'b0}};
         rd_err_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         slot_valid_q <= slot_valid_d;
         slot_wr_q    <= slot_wr_d;
         slot_be_q    <= slot_be_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         ready_q      <= ready_d;
         drop_q       <= drop_d;
         rd_rdy_q     <= rd_rdy_d;
         rdata_q      <= rdata_d;
         bus_wr_en_q  <= bus_wr_en_d;
         bus_rd_en_q  <= bus_rd_en_d;
         bus_be_q     <= bus_be_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
`ifdef REG_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         rd_err_q     <= rd_err_d;
`endif
      end
   end

   assign m0_ready  = ready_q[0];
   assign m1_ready  = ready_q[1];
   assign m0_drop   = drop_q[0];
   assign m1_drop   = drop_q[1];
   assign m0_rd_rdy = rd_rdy_q[0];
   assign m1_rd_rdy = rd_rdy_q[1];
   assign m0_rdata  = rdata_q[0];
   assign m1_rdata  = rdata_q[1];
   assign bus_wr_en = bus_wr_en_q;
   assign bus_rd_en = bus_rd_en_q;
   assign bus_be    = bus_be_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: a cycle-level transaction model predicts every
// strobe, read return, drop and timeout; a monitor pops and compares as the DUT shows them.
module tb_reg_bus_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic m0_wr_en = 1'b0, m0_rd_en = 1'b0, m1_wr_en = 1'b0, m1_rd_en = 1'b0;
   logic [3:0] m0_be = 4'h0, m1_be = 4'h0;
   logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0;
   logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
   logic m0_ready, m1_ready, m0_rd_rdy, m1_rd_rdy, m0_drop, m1_drop;
   logic [31:0] m0_rdata, m1_rdata;
   logic bus_wr_en, bus_rd_en, rd_err;
   logic [3:0] bus_be;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = 32'h0;
   logic bus_rd_rdy = 1'b0;

   reg_bus_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rstb(rstb),
      .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rd_rdy(m0_rd_rdy), .m0_drop(m0_drop),
      .m1_wr_en(m1_wr_en), .m1_rd_en(m1_rd_en), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rd_rdy(m1_rd_rdy), .m1_drop(m1_drop),
      .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rd_rdy(bus_rd_rdy), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [3:0]  be;
      logic [15:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t bus_q[$], rd0_q[$], rd1_q[$], drop0_q[$], drop1_q[$], err_q[$];

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   bit  done = 1'b0;

   // slave controls
   bit          slave_silent = 1'b0;
   bit          force_rdy = 1'b0;
   int          fix_dly = -1;
   logic [31:0] fix_data[$];

   // reference model state: pending slot per master, the transaction on the bus, and history
   bit          sv[2] = '{1'b0, 1'b0};
   bit          swr[2];
   logic [3:0]  sbe[2];
   logic [15:0] sad[2];
   logic [31:0] sdt[2];
   int          busy = 0;       // 0 bus free, 1 write in its single cycle, 2 read waiting
   int          own = 0;
   int          lastg = 1;
   int          rd_cycles = 0;  // which RD_WAIT cycle the read is in, counting from 1
   logic [31:0] mrd[2] = '{32'h0, 32'h0};
   logic [3:0]  lbe = 4'h0;
   logic [15:0] lad = 16'h0;
   logic [31:0] ldt = 32'h0;

   function automatic ev_t mk(input int c, input logic wr, input logic [3:0] be,
                              input logic [15:0] a, input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.wr = wr; e.be = be; e.addr = a; e.data = d;
      return e;
   endfunction

   function automatic bit exp_ready(input int n);
      return !sv[n] && !(busy != 0 && own == n);
   endfunction

   // Reference model, evaluated at each rising edge from the inputs of the ending cycle.
   initial begin
      bit          pw[2], pr[2], rdy_now[2];
      logic [3:0]  pb[2];
      logic [15:0] pa[2];
      logic [31:0] pd[2];
      int          old_busy, g;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rstb) begin
            sv = '{1'b0, 1'b0}; busy = 0; own = 0; lastg = 1; rd_cycles = 0;
            mrd = '{32'h0, 32'h0}; lbe = 4'h0; lad = 16'h0; ldt = 32'h0;
            bus_q.delete(); rd0_q.delete(); rd1_q.delete();
            drop0_q.delete(); drop1_q.delete(); err_q.delete();
         end else begin
            pw[0] = m0_wr_en; pr[0] = m0_rd_en; pb[0] = m0_be; pa[0] = m0_addr; pd[0] = m0_wdata;
            pw[1] = m1_wr_en; pr[1] = m1_rd_en; pb[1] = m1_be; pa[1] = m1_addr; pd[1] = m1_wdata;
            for (int n = 0; n < 2; n++) rdy_now[n] = exp_ready(n);
            old_busy = busy;
            if (busy == 2) begin
               if (bus_rd_rdy) begin
                  mrd[own] = bus_rdata;
                  if (own == 0) rd0_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, bus_rdata));
                  else          rd1_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, bus_rdata));
                  busy = 0;
               end
`ifdef REG_ARB_TIMEOUT_EN
               else if (rd_cycles == TO) begin
                  mrd[own] = 32'hDEAD_BEEF;
                  if (own == 0) rd0_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, 32'hDEAD_BEEF));
                  else          rd1_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, 32'hDEAD_BEEF));
                  err_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, 32'h0));
                  busy = 0;
               end
`endif
               else rd_cycles++;
            end else if (busy == 1) begin
               busy = 0;
            end
            if (old_busy == 0 && (sv[0] || sv[1])) begin
               if (sv[0] && sv[1]) g = (lastg == 0) ? 1 : 0;
               else g = sv[0] ? 0 : 1;
               lastg = g; own = g; sv[g] = 1'b0; rd_cycles = 1;
               busy = swr[g] ? 1 : 2;
               lbe = sbe[g]; lad = sad[g]; ldt = sdt[g];
               bus_q.push_back(mk(cyc, swr[g], sbe[g], sad[g], sdt[g]));
            end
            for (int n = 0; n < 2; n++) begin
               if (pw[n] || pr[n]) begin
                  if (rdy_now[n]) begin
                     sv[n] = 1'b1; swr[n] = pw[n]; sbe[n] = pb[n]; sad[n] = pa[n]; sdt[n] = pd[n];
                  end else if (n == 0) drop0_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, 32'h0));
                  else                 drop1_q.push_back(mk(cyc, 1'b0, 4'h0, 16'h0, 32'h0));
               end
            end
         end
      end
   end

   task automatic chk_ev(input string nm, input logic seen, input int n, input int fc, output bit do_pop);
      do_pop = 1'b0;
      if (seen) begin
         checks++;
         if (n == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse at cycle %0d, required none", nm, cyc);
         end else begin
            do_pop = 1'b1;
            if (fc != cyc) begin
               errors++;
               $display("FAIL %s: pulse at cycle %0d, required at cycle %0d", nm, cyc, fc);
            end
         end
      end else if (n != 0 && fc <= cyc) begin
         checks++; errors++; do_pop = 1'b1;
         $display("FAIL %s: no pulse at cycle %0d, required at cycle %0d", nm, cyc, fc);
      end
   endtask

   task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: per-cycle level checks and scoreboard pops on every DUT pulse.
   initial begin
      bit pp;
      ev_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            chk_val("queues_drained", 64'(bus_q.size() + rd0_q.size() + rd1_q.size() + drop0_q.size()
                    + drop1_q.size() + err_q.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         if (rstb) begin
            chk_val("m0_ready", 64'(m0_ready), 64'(exp_ready(0)));
            chk_val("m1_ready", 64'(m1_ready), 64'(exp_ready(1)));
            chk_val("m0_rdata", 64'(m0_rdata), 64'(mrd[0]));
            chk_val("m1_rdata", 64'(m1_rdata), 64'(mrd[1]));
            chk_val("bus_fields", {12'h0, bus_be, bus_addr, bus_wdata}, {12'h0, lbe, lad, ldt});

            chk_ev("bus_strobe", bus_wr_en | bus_rd_en, bus_q.size(), bus_q.size() ? bus_q[0].cyc : 0, pp);
            if (pp) begin
               e = bus_q.pop_front();
               if (bus_wr_en | bus_rd_en)
                  chk_val("bus_request", {10'h0, bus_wr_en, bus_rd_en, bus_be, bus_addr, bus_wdata},
                          {10'h0, e.wr, ~e.wr, e.be, e.addr, e.data});
            end
            chk_ev("m0_rd_rdy", m0_rd_rdy, rd0_q.size(), rd0_q.size() ? rd0_q[0].cyc : 0, pp);
            if (pp) begin
               e = rd0_q.pop_front();
               if (m0_rd_rdy) chk_val("m0_rd_data", 64'(m0_rdata), 64'(e.data));
            end
            chk_ev("m1_rd_rdy", m1_rd_rdy, rd1_q.size(), rd1_q.size() ? rd1_q[0].cyc : 0, pp);
            if (pp) begin
               e = rd1_q.pop_front();
               if (m1_rd_rdy) chk_val("m1_rd_data", 64'(m1_rdata), 64'(e.data));
            end
            chk_ev("m0_drop", m0_drop, drop0_q.size(), drop0_q.size() ? drop0_q[0].cyc : 0, pp);
            if (pp) e = drop0_q.pop_front();
            chk_ev("m1_drop", m1_drop, drop1_q.size(), drop1_q.size() ? drop1_q[0].cyc : 0, pp);
            if (pp) e = drop1_q.pop_front();
            chk_ev("rd_err", rd_err, err_q.size(), err_q.size() ? err_q[0].cyc : 0, pp);
            if (pp) e = err_q.pop_front();
         end
      end
   end

   // Register slave: answers each read after a random (or fixed) delay, sometimes glitches rd_rdy when idle.
   initial begin
      int pend = 0;
      int dly = 0;
      forever begin
         @(negedge clk);
         #1;
         bus_rd_rdy = 1'b0;
         bus_rdata  = $urandom;
         if (!rstb) begin
            pend = 0;
         end else begin
            if (bus_rd_en) begin
               pend = 1;
               dly  = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 4);
            end
            if (force_rdy) begin
               bus_rd_rdy = 1'b1;
            end else if (slave_silent) begin
               bus_rd_rdy = 1'b0;
            end else if (pend != 0) begin
               if (dly == 0) begin
                  bus_rd_rdy = 1'b1;
                  pend = 0;
                  if (fix_data.size() > 0) bus_rdata = fix_data.pop_front();
               end else begin
                  dly--;
               end
            end else begin
               bus_rd_rdy = ($urandom_range(0, 15) == 0);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
      m0_wr_en = 1'b0; m0_rd_en = 1'b0; m1_wr_en = 1'b0; m1_rd_en = 1'b0;
   endtask

   task automatic drive(input int n, input logic wr, input logic rd, input logic [3:0] be,
                        input logic [15:0] a, input logic [31:0] d);
      if (n == 0) begin
         m0_wr_en = wr; m0_rd_en = rd; m0_be = be; m0_addr = a; m0_wdata = d;
      end else begin
         m1_wr_en = wr; m1_rd_en = rd; m1_be = be; m1_addr = a; m1_wdata = d;
      end
   endtask

   task automatic do_reset();
      step();
      rstb = 1'b0;
      repeat (3) step();
      rstb = 1'b1;
      step();
   endtask

   initial begin
      repeat (3) step();
      rstb = 1'b1;
      repeat (2) step();

      // single m0 write
      drive(0, 1'b1, 1'b0, 4'h1, 16'h0010, 32'h0000_005A);
      step();
      repeat (6) step();

      // simultaneous reads, slave answers 0x11 then 0x22 after 3 cycles each
      fix_dly = 3;
      fix_data.push_back(32'h0000_0011);
      fix_data.push_back(32'h0000_0022);
      drive(0, 1'b0, 1'b1, 4'hF, 16'h0100, 32'h0);
      drive(1, 1'b0, 1'b1, 4'hF, 16'h0200, 32'h0);
      step();
      repeat (16) step();
      fix_dly = -1;

      // four rounds of simultaneous writes
      for (int r = 0; r < 4; r++) begin
         drive(0, 1'b1, 1'b0, 4'h3, 16'(16'h1000 + r), 32'(32'hA000 + r));
         drive(1, 1'b1, 1'b1, 4'hC, 16'(16'h2000 + r), 32'(32'hB000 + r));
         step();
         repeat (6) step();
      end

      // m1 second pulse while its slot is still pending
      drive(1, 1'b1, 1'b0, 4'hF, 16'h3000, 32'h1234_5678);
      step();
      drive(1, 1'b1, 1'b0, 4'hF, 16'h3004, 32'h8765_4321);
      step();
      repeat (6) step();

      // read that the slave never answers
      slave_silent = 1'b1;
      drive(0, 1'b0, 1'b1, 4'hF, 16'h0040, 32'h0);
      step();
      repeat (20) step();
      slave_silent = 1'b0;
      do_reset();

      // reset in the middle of a read, then a late bus_rd_rdy
      slave_silent = 1'b1;
      drive(1, 1'b0, 1'b1, 4'hF, 16'h0080, 32'h0);
      step();
      repeat (3) step();
      rstb = 1'b0;
      repeat (3) step();
      rstb = 1'b1;
      slave_silent = 1'b0;
      step();
      force_rdy = 1'b1;
      step();
      force_rdy = 1'b0;
      repeat (3) step();
      drive(1, 1'b0, 1'b1, 4'hF, 16'h0084, 32'h0);
      drive(0, 1'b1, 1'b0, 4'h5, 16'h0088, 32'hCAFE_0001);
      step();
      repeat (12) step();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         for (int n = 0; n < 2; n++) begin
            if ($urandom_range(0, 2) == 0) begin
               logic w, rd;
               w  = 1'($urandom_range(0, 1));
               rd = w ? 1'($urandom_range(0, 1)) : 1'b1;
               drive(n, w, rd, 4'($urandom), 16'($urandom), $urandom);
            end
         end
         step();
      end
      repeat (20) step();
      done = 1'b1;
      repeat (5) @(negedge clk);
      $display("FAIL monitor: summary not reached, required summary after done");
      $fatal(1);
   end
endmodule
